// File: rtl/hw_accel_frame_sched_if.sv
// Control/status bundle between the DMA/control glue (master) and the
// frame scheduler (slave).
interface hw_accel_frame_sched_if;
  // Glue -> scheduler
  logic        start;
  logic        continuous;
  logic        in_beat;
  logic        out_beat;
  logic        err_clr;
  // Scheduler -> glue / accelerator wrapper
  logic        out_en;
  logic        out_last;
  logic        accel_rst;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        timeout_err;
  logic        in_overrun;

  modport master (
    output start, continuous, in_beat, out_beat, err_clr,
    input  out_en, out_last, accel_rst, busy, frame_done, frame_count,
           timeout_err, in_overrun
  );

  modport slave (
    input  start, continuous, in_beat, out_beat, err_clr,
    output out_en, out_last, accel_rst, busy, frame_done, frame_count,
           timeout_err, in_overrun
  );
endinterface

// File: rtl/hw_accel_frame_sched.sv
// Frame-level scheduler for the accelerator DMA datapath: arms the output
// stream on a start edge, counts input/output beats per frame, drives wlast
// at DMA transfer boundaries, flushes the accelerator at each frame end.
// Optional macro HW_ACCEL_FRAME_WATCHDOG_EN adds the idle-beat watchdog that
// aborts stalled frames; without it timeout_err is constant 0.
module hw_accel_frame_sched #(
  parameter int FRAME_WIDTH         = 640,
  parameter int FRAME_HEIGHT        = 480,
  parameter int DMA_TRANSFER_LENGTH = 1920,
  parameter int FLUSH_CYCLES        = 4,
  parameter int TIMEOUT_CYCLES      = 1048576
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hw_accel_frame_sched_if.slave bus
);

  localparam int FRAME_WORDS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int IN_W        = $clog2(FRAME_WORDS + 1);
  localparam int OUT_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int BURST_W     = (DMA_TRANSFER_LENGTH > 1) ? $clog2(DMA_TRANSFER_LENGTH) : 1;
  localparam int FLUSH_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [IN_W-1:0]    IN_FULL   = IN_W'(FRAME_WORDS);
  localparam logic [OUT_W-1:0]   OUT_FINAL = OUT_W'(FRAME_WORDS - 1);
  localparam logic [BURST_W-1:0] BURST_END = BURST_W'(DMA_TRANSFER_LENGTH - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_END = FLUSH_W'(FLUSH_CYCLES - 1);

  // Reject parameter sets the counters cannot represent correctly.
  if (FLUSH_CYCLES < 1 || TIMEOUT_CYCLES < 2 ||
      (FRAME_WORDS % DMA_TRANSFER_LENGTH) != 0) begin : g_bad_params
    $error("hw_accel_frame_sched: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, ARM, RUN, FLUSH, DONE} state_t;

  state_t             state_reg;
  logic               start_prev_reg;
  logic               ok_reg;
  logic [IN_W-1:0]    in_cnt_reg;
  logic [OUT_W-1:0]   out_cnt_reg;
  logic [BURST_W-1:0] burst_cnt_reg;
  logic [FLUSH_W-1:0] flush_cnt_reg;
  logic               out_en_reg;
  logic               accel_rst_reg;
  logic               busy_reg;
  logic               frame_done_reg;
  logic [15:0]        frame_count_reg;
  logic               in_overrun_reg;
  logic               start_edge;

`ifdef HW_ACCEL_FRAME_WATCHDOG_EN
  localparam int              WD_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_END = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt_reg;
  logic            timeout_err_reg;
  assign bus.timeout_err = timeout_err_reg;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // The detector tracks start in every state, so a held-high start never retriggers.
  assign start_edge = bus.start & ~start_prev_reg;

  // wlast is purely a function of the burst position and the live beat.
  assign bus.out_last = bus.out_beat && (burst_cnt_reg == BURST_END);

  assign bus.out_en      = out_en_reg;
  assign bus.accel_rst   = accel_rst_reg;
  assign bus.busy        = busy_reg;
  assign bus.frame_done  = frame_done_reg;
  assign bus.frame_count = frame_count_reg;
  assign bus.in_overrun  = in_overrun_reg;

  // Frame sequencer: state, beat counters, sticky flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      start_prev_reg  <= 1'b0;
      ok_reg          <= 1'b0;
      in_cnt_reg      <= '0;
      out_cnt_reg     <= '0;
      burst_cnt_reg   <= '0;
      flush_cnt_reg   <= '0;
      out_en_reg      <= 1'b0;
      accel_rst_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
      in_overrun_reg  <= 1'b0;
`ifdef HW_ACCEL_FRAME_WATCHDOG_EN
      wd_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
`endif
    end else begin
      start_prev_reg <= bus.start;
      frame_done_reg <= 1'b0;
      // Clears first; any set later in this cycle overrides them.
      if (bus.err_clr) begin
        in_overrun_reg <= 1'b0;
`ifdef HW_ACCEL_FRAME_WATCHDOG_EN
        timeout_err_reg <= 1'b0;
`endif
      end
      case (state_reg)
        IDLE: begin
          if (start_edge) begin
            state_reg <= ARM;
            busy_reg  <= 1'b1;
          end
        end
        ARM: begin
          in_cnt_reg    <= '0;
          out_cnt_reg   <= '0;
          burst_cnt_reg <= '0;
`ifdef HW_ACCEL_FRAME_WATCHDOG_EN
          wd_cnt_reg    <= '0;
`endif
          out_en_reg    <= 1'b1;
          state_reg     <= RUN;
        end
        RUN: begin
          if (bus.in_beat) begin
            if (in_cnt_reg == IN_FULL) in_overrun_reg <= 1'b1;
            else                       in_cnt_reg     <= in_cnt_reg + 1'b1;
          end
          if (bus.out_beat) begin
            out_cnt_reg   <= out_cnt_reg + 1'b1;
            burst_cnt_reg <= (burst_cnt_reg == BURST_END) ? '0 : burst_cnt_reg + 1'b1;
          end
`ifdef HW_ACCEL_FRAME_WATCHDOG_EN
          if (bus.in_beat || bus.out_beat) wd_cnt_reg <= '0;
          else                             wd_cnt_reg <= wd_cnt_reg + 1'b1;
`endif
          if (bus.out_beat && out_cnt_reg == OUT_FINAL) begin
            state_reg     <= FLUSH;
            ok_reg        <= 1'b1;
            out_en_reg    <= 1'b0;
            accel_rst_reg <= 1'b1;
            flush_cnt_reg <= '0;
          end
`ifdef HW_ACCEL_FRAME_WATCHDOG_EN
          else if (!bus.in_beat && !bus.out_beat && wd_cnt_reg == WD_END) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= FLUSH;
            ok_reg          <= 1'b0;
            out_en_reg      <= 1'b0;
            accel_rst_reg   <= 1'b1;
            flush_cnt_reg   <= '0;
          end
`endif
        end
        FLUSH: begin
          if (flush_cnt_reg == FLUSH_END) begin
            accel_rst_reg <= 1'b0;
            if (ok_reg) begin
              state_reg       <= DONE;
              frame_done_reg  <= 1'b1;
              frame_count_reg <= frame_count_reg + 16'd1;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (bus.continuous) begin
            state_reg <= ARM;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hw_accel_frame_sched.sv
// Directed bench for hw_accel_frame_sched with an 8x4 frame, 8-word DMA
// transfers, 4-cycle flush and 64-cycle watchdog. Watchdog scenario adapts
// to whether HW_ACCEL_FRAME_WATCHDOG_EN is defined.
module tb_hw_accel_frame_sched;

  localparam int FW    = 8;
  localparam int FH    = 4;
  localparam int WORDS = FW * FH;
  localparam int DMA   = 8;
  localparam int FLUSH = 4;
  localparam int TMO   = 64;

  logic clk;
  logic rst_n;
  hw_accel_frame_sched_if bus ();

  hw_accel_frame_sched #(
    .FRAME_WIDTH        (FW),
    .FRAME_HEIGHT       (FH),
    .DMA_TRANSFER_LENGTH(DMA),
    .FLUSH_CYCLES       (FLUSH),
    .TIMEOUT_CYCLES     (TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per output beat of a frame: idle cycles before it and the
  // expected wlast (every 8th beat).
  typedef struct {
    int gap;
    bit exp_last;
  } beat_vec_t;

  beat_vec_t vecs [WORDS];
  int checks     = 0;
  int failures   = 0;
  int exp_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of beats, sample the combinational wlast mid-cycle.
  task automatic do_cycle(input bit ib, input bit ob, output bit last);
    bus.in_beat  = ib;
    bus.out_beat = ob;
    #1;
    last = bus.out_last;
    step();
    bus.in_beat  = 1'b0;
    bus.out_beat = 1'b0;
  endtask

  // Start edge in cycle N; out_en must be low in N+1 (ARM) and high in N+2.
  task automatic start_frame(input bit hold);
    bus.start = 1'b1;
    step();
    if (!hold) bus.start = 1'b0;
    chk("arm_out_en", bus.out_en, 1'b0);
    step();
    chk("run_out_en", bus.out_en, 1'b1);
    chk("run_busy", bus.busy, 1'b1);
  endtask

  // Stream output beats [from..to] in lockstep with input beats, after
  // 'extra' input-only beats.
  task automatic stream_beats(input int from, input int to, input int extra);
    bit l;
    for (int e = 0; e < extra; e++) do_cycle(1'b1, 1'b0, l);
    for (int k = from; k <= to; k++) begin
      for (int g = 0; g < vecs[k].gap; g++) do_cycle(1'b0, 1'b0, l);
      chk("out_en_run", bus.out_en, 1'b1);
      do_cycle(1'b1, 1'b1, l);
      chk($sformatf("out_last_beat%0d", k + 1), l, vecs[k].exp_last);
      chk("in_overrun", bus.in_overrun, (extra + k >= WORDS) ? 1'b1 : 1'b0);
    end
  endtask

  // Called in cycle M+1 after the final beat in cycle M.
  task automatic frame_end_check(input bit cont);
    for (int i = 0; i < FLUSH; i++) begin
      chk("flush_accel_rst", bus.accel_rst, 1'b1);
      chk("flush_out_en", bus.out_en, 1'b0);
      step();
    end
    exp_frames++;
    chk("done_accel_rst", bus.accel_rst, 1'b0);
    chk("done_pulse", bus.frame_done, 1'b1);
    chk("done_out_en", bus.out_en, 1'b0);
    step();
    chk("done_pulse_end", bus.frame_done, 1'b0);
    chk("frame_count", bus.frame_count, exp_frames);
    if (cont) begin
      chk("rearm_out_en", bus.out_en, 1'b0);
      chk("rearm_busy", bus.busy, 1'b1);
      step();
      chk("rerun_out_en", bus.out_en, 1'b1);
    end else begin
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_out_en", bus.out_en, 1'b0);
    end
    $display("txn frame_end count=%0d continuous=%0d", bus.frame_count, cont);
  endtask

  initial begin
    for (int k = 0; k < WORDS; k++) begin
      vecs[k].gap      = k % 3;
      vecs[k].exp_last = ((k + 1) % DMA) == 0;
    end

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.in_beat    = 1'b0;
    bus.out_beat   = 1'b0;
    bus.err_clr    = 1'b0;
    #22;
    chk("rst_out_en", bus.out_en, 1'b0);
    chk("rst_accel_rst", bus.accel_rst, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_frame_done", bus.frame_done, 1'b0);
    chk("rst_frame_count", bus.frame_count, 16'd0);
    chk("rst_timeout_err", bus.timeout_err, 1'b0);
    chk("rst_in_overrun", bus.in_overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single frame
    start_frame(1'b0);
    stream_beats(0, WORDS - 1, 0);
    frame_end_check(1'b0);

    // Start held high through a frame plus a spurious edge during RUN
    start_frame(1'b1);
    stream_beats(0, 9, 0);
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    stream_beats(10, WORDS - 1, 0);
    frame_end_check(1'b0);
    repeat (10) step();
    chk("held_start_busy", bus.busy, 1'b0);
    chk("held_start_count", bus.frame_count, exp_frames);
    bus.start = 1'b0;
    step();

    // Continuous: one start edge, three frames
    bus.continuous = 1'b1;
    start_frame(1'b0);
    stream_beats(0, WORDS - 1, 0);
    frame_end_check(1'b1);
    stream_beats(0, WORDS - 1, 0);
    frame_end_check(1'b1);
    stream_beats(0, WORDS - 1, 0);
    bus.continuous = 1'b0;
    frame_end_check(1'b0);
    chk("cont_count", bus.frame_count, 16'd5);

    // Overrun: one extra input beat, so the 33rd arrives with the last output beat
    start_frame(1'b0);
    stream_beats(0, WORDS - 1, 1);
    frame_end_check(1'b0);
    chk("overrun_sticky", bus.in_overrun, 1'b1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("overrun_clr", bus.in_overrun, 1'b0);

    // Watchdog: beats stop after output beat 10
    start_frame(1'b0);
    stream_beats(0, 9, 0);
`ifdef HW_ACCEL_FRAME_WATCHDOG_EN
    repeat (TMO - 1) step();
    chk("wd_not_yet", bus.timeout_err, 1'b0);
    chk("wd_still_run", bus.out_en, 1'b1);
    step();
    chk("wd_timeout", bus.timeout_err, 1'b1);
    chk("wd_accel_rst", bus.accel_rst, 1'b1);
    chk("wd_out_en", bus.out_en, 1'b0);
    for (int i = 1; i < FLUSH; i++) begin
      step();
      chk("wd_flush_accel_rst", bus.accel_rst, 1'b1);
    end
    step();
    chk("wd_flush_end", bus.accel_rst, 1'b0);
    chk("wd_idle_busy", bus.busy, 1'b0);
    chk("wd_no_done", bus.frame_done, 1'b0);
    step();
    chk("wd_count", bus.frame_count, exp_frames);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("wd_err_clr", bus.timeout_err, 1'b0);
    $display("txn watchdog_abort count=%0d", bus.frame_count);
`else
    repeat (2 * TMO) step();
    chk("nowd_timeout", bus.timeout_err, 1'b0);
    chk("nowd_busy", bus.busy, 1'b1);
    chk("nowd_out_en", bus.out_en, 1'b1);
    stream_beats(10, WORDS - 1, 0);
    frame_end_check(1'b0);
`endif

    // Asynchronous reset during output beat 20
    start_frame(1'b0);
    stream_beats(0, 18, 0);
    bus.in_beat  = 1'b1;
    bus.out_beat = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_en", bus.out_en, 1'b0);
    chk("arst_accel_rst", bus.accel_rst, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_frame_count", bus.frame_count, 16'd0);
    chk("arst_out_last", bus.out_last, 1'b0);
    chk("arst_in_overrun", bus.in_overrun, 1'b0);
    chk("arst_timeout_err", bus.timeout_err, 1'b0);
    bus.in_beat  = 1'b0;
    bus.out_beat = 1'b0;
    exp_frames   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start_frame(1'b0);
    stream_beats(0, WORDS - 1, 0);
    frame_end_check(1'b0);
    chk("post_rst_count", bus.frame_count, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hw_accel_frame_sched.md
# hw_accel_frame_sched

Frame-level scheduler for the TinyML hardware-accelerator DMA datapath. It arms the output DMA stream on a software start and counts input and output beats per frame. It emits `wlast` at each DMA transfer boundary, applies a fixed-length flush reset to the accelerator and its FIFOs at every frame end, and aborts stalled frames with a watchdog. It sits between the DMA/control glue and the accelerator wrapper, and replaces ad-hoc per-frame sequencing inside the wrapper.

## Interface
- `FRAME_WIDTH`, 640, pixels per line
- `FRAME_HEIGHT`, 480, lines per frame; `FRAME_WORDS` = `FRAME_WIDTH*FRAME_HEIGHT`
- `DMA_TRANSFER_LENGTH`, 1920, output words per DMA transfer; `FRAME_WORDS` must be an integer multiple
- `FLUSH_CYCLES`, 4, accelerator reset pulse length in cycles (≥1)
- `TIMEOUT_CYCLES`, 1048576, idle-beat watchdog limit in cycles (≥2)
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level from control register; a rising edge requests one frame
- `continuous`  in  1  1 = re-arm automatically after each frame
- `in_beat`  in  1  one input word accepted by the accelerator this cycle
- `out_beat`  in  1  one output word accepted by the DMA this cycle (`dma_wvalid`)
- `err_clr`  in  1  clears the sticky error flags
- `out_en`  out  1  permits the output FIFO to drain into the DMA
- `out_last`  out  1  `wlast` for the current output beat
- `accel_rst`  out  1  synchronous flush reset to the accelerator and both FIFOs
- `busy`  out  1  high in any state other than IDLE
- `frame_done`  out  1  one-cycle pulse on successful frame completion
- `frame_count`  out  16  completed-frame count; wraps 0xFFFF→0
- `timeout_err`  out  1  sticky; a frame was aborted by the watchdog
- `in_overrun`  out  1  sticky; an input beat arrived after `FRAME_WORDS` inputs had already been received in the frame

## Operation
- States: IDLE, ARM, RUN, FLUSH, DONE.
- **IDLE**
  - On a `start` rising edge (registered previous value vs. current value): go to ARM.
- **ARM** (1 cycle)
  - Clear the input counter, output counter, burst counter and watchdog.
  - Go to RUN.
- **RUN**
  - `out_en`=1.
  - `in_cnt` increments on `in_beat`, saturating at `FRAME_WORDS`.
  - An `in_beat` while `in_cnt`==`FRAME_WORDS` sets `in_overrun`.
  - `out_cnt` increments on `out_beat`.
  - `burst_cnt` increments on `out_beat` and wraps to 0 after `DMA_TRANSFER_LENGTH`-1.
  - `out_beat` with `out_cnt`==`FRAME_WORDS`-1: go to FLUSH with `ok`=1.
- **Watchdog** (RUN only)
  - Cleared by any `in_beat` or `out_beat`; otherwise increments.
  - On reaching `TIMEOUT_CYCLES`-1: set `timeout_err`, go to FLUSH with `ok`=0.
- **FLUSH**
  - `accel_rst`=1 and `out_en`=0 for exactly `FLUSH_CYCLES` cycles.
  - Exit to DONE if `ok`=1, else to IDLE.
  - Beats arriving during FLUSH are ignored.
- **DONE** (1 cycle)
  - `frame_done`=1; `frame_count`++.
  - Next state: ARM if `continuous`, otherwise IDLE.
- **Start edges**
  - A `start` edge outside IDLE is dropped.
  - The edge detector still tracks `start` in every state, so a held-high `start` does not retrigger.
- **Sticky flags**
  - `err_clr` clears `timeout_err` and `in_overrun`.
  - If `err_clr` and a new error event occur in the same cycle, the set wins.

## Timing
- Reset values:
  - `out_en`, `accel_rst`, `busy`, `frame_done`, `timeout_err`, `in_overrun` = 0
  - `frame_count` = 0; state = IDLE
  - all counters = 0
- `out_last` is combinational: `out_beat && burst_cnt==DMA_TRANSFER_LENGTH-1`; it is not gated by state.
  - The final beat of a frame always has `out_last`=1.
- All other outputs are registered.
- Start-to-run latency:
  - `start` rises in cycle N → ARM in N+1 → `out_en`=1 and `busy`=1 from N+2.
- Frame-end sequence, with the last `out_beat` in cycle M:
  - `out_en`=0 and `accel_rst`=1 in cycles M+1 … M+`FLUSH_CYCLES`.
  - `frame_done` in M+`FLUSH_CYCLES`+1.
  - Continuous mode: `out_en`=1 again at M+`FLUSH_CYCLES`+3.
- Watchdog abort:
  - 0 beats for `TIMEOUT_CYCLES` consecutive RUN cycles → `timeout_err` set on the next edge, FLUSH follows, and there is no `frame_done`.
- Asynchronous `rst_n` mid-frame:
  - All outputs go to their reset values immediately.
  - The accelerator is not flushed by this block; system reset covers it.

## Configuration
- Macro: `HW_ACCEL_FRAME_WATCHDOG_EN`.
- Defined: the watchdog counter and abort path are present as described.
- Undefined:
  - No watchdog counter is synthesized; `timeout_err` is tied to 0.
  - RUN exits only on the final output beat.
  - `err_clr` affects only `in_overrun`.

## Test plan
All scenarios use `FRAME_WIDTH`=8, `FRAME_HEIGHT`=4, `DMA_TRANSFER_LENGTH`=8, `FLUSH_CYCLES`=4, `TIMEOUT_CYCLES`=64.
- **Single frame:** `start` edge, then 32 `in_beat` and 32 `out_beat` with gaps.
  - `out_last` on output beats 8, 16, 24, 32.
  - `accel_rst` high for exactly 4 cycles after beat 32.
  - One `frame_done` pulse; `frame_count`=1; `busy`=0 afterwards.
- **Continuous:** `continuous`=1, single `start` edge, 3 frames streamed.
  - `frame_count`=3.
  - `out_en` low for exactly 6 cycles between frames.
  - No extra start required.
- **Watchdog:** stop beats after output beat 10.
  - `timeout_err`=1 after 64 idle cycles, then a 4-cycle `accel_rst`.
  - No `frame_done`; `frame_count` unchanged; state IDLE.
  - `err_clr` → `timeout_err`=0.
- **Overrun:** 33 `in_beat` during RUN.
  - `in_overrun`=1 on the 33rd beat.
  - The frame still completes on output beat 32.
- **Reset mid-frame:** drop `rst_n` at output beat 20.
  - All outputs 0 asynchronously; `frame_count`=0.
  - A new `start` edge produces a full 32-beat frame with `out_last` on beat 8.
- **Start held/spurious:** `start` held high through a frame, plus a second edge during RUN.
  - Exactly one frame is run; `frame_count`=1.
